// File: rtl/acam_fifo_readout.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// acam_fifo_readout
//   Reader side of the ACAM TDC-GPX FIFO interface on the FMC-TDC mezzanine.
//   It synchronises the two FIFO empty flags and runs one complete CS/OE/ADR/RD
//   bus read for each non-empty FIFO, taking turns when both have data. The
//   28-bit word it captures goes out on a valid/ready stream. Clock domain:
//   125 MHz TDC clock.
//
//   Optional feature: define ACAM_RD_STATS_EN to build the 32-bit read counter
//   on rd_count_o. With the macro undefined, rd_count_o is tied to 0.
//
// Ports
//   clk_i, rst_n_i        clock, asynchronous active-low reset
//   acq_en_i              acquisition enable; gates only the start of a read
//   ef1_i, ef2_i          ACAM FIFO empty flags (async, 1 = empty)
//   data_i[27:0]          ACAM data bus
//   adr_o[3:0]            ACAM address bus
//   cs_n_o, oe_n_o, rd_n_o ACAM bus strobes, active low, registered
//   tstamp_o[27:0]        captured word
//   tstamp_fifo_o         source FIFO of tstamp_o (0 = FIFO1, 1 = FIFO2)
//   tstamp_valid_o        stream valid
//   tstamp_ready_i        stream ready
//   busy_o                FSM not in IDLE
//   rd_count_o[31:0]      words read since reset (wraps)
// -----------------------------------------------------------------------------
module acam_fifo_readout #(
    parameter int unsigned RD_PULSE_CYCLES = 2,
    parameter int unsigned EF_HOLDOFF      = 4,
    parameter logic [3:0]  ADR_FIFO1       = 4'd8,
    parameter logic [3:0]  ADR_FIFO2       = 4'd9
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        acq_en_i,
    input  logic        ef1_i,
    input  logic        ef2_i,
    input  logic [27:0] data_i,
    output logic [3:0]  adr_o,
    output logic        cs_n_o,
    output logic        oe_n_o,
    output logic        rd_n_o,
    output logic [27:0] tstamp_o,
    output logic        tstamp_fifo_o,
    output logic        tstamp_valid_o,
    input  logic        tstamp_ready_i,
    output logic        busy_o,
    output logic [31:0] rd_count_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_RD,
        S_OUTPUT,
        S_HOLDOFF
    } state_t;

    // One counter serves both the RD pulse width and the post-read holdoff.
    localparam int unsigned CNT_MAX = (RD_PULSE_CYCLES > EF_HOLDOFF) ? RD_PULSE_CYCLES : EF_HOLDOFF;
    localparam int unsigned CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

    state_t             state_q, state_d;
    logic               ef1_meta_q, ef1_s_q;
    logic               ef2_meta_q, ef2_s_q;
    logic               sel_q, sel_d;     // FIFO being read
    logic               rr_q, rr_d;       // preferred FIFO when both have data
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         adr_q, adr_d;
    logic               cs_n_q, cs_n_d;
    logic               oe_n_q, oe_n_d;
    logic               rd_n_q, rd_n_d;
    logic [27:0]        tstamp_q, tstamp_d;
    logic               fifo_q, fifo_d;
    logic               valid_q, valid_d;
    logic               word_done;
    logic               pick;
    logic [CNT_W-1:0]   cnt_sat_inc;
    logic               hold_done;

    // Two-flop synchronisers. The reset value is "empty", so nothing is read
    // until a real flag has gone through both stages.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ef1_meta_q <= 1'b1;
            ef1_s_q    <= 1'b1;
            ef2_meta_q <= 1'b1;
            ef2_s_q    <= 1'b1;
        end else begin
            ef1_meta_q <= ef1_i;
            ef1_s_q    <= ef1_meta_q;
            ef2_meta_q <= ef2_i;
            ef2_s_q    <= ef2_meta_q;
        end
    end

    // Holdoff is counted from the rd_n release edge, so the cycles spent in
    // OUTPUT count toward it. If the consumer stalls long enough, HOLDOFF
    // lasts a single cycle.
    assign cnt_sat_inc = (cnt_q == CNT_W'(EF_HOLDOFF)) ? cnt_q : cnt_q + CNT_W'(1);
    assign hold_done   = (32'(cnt_q) + 32'd1) >= 32'(EF_HOLDOFF);

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        rr_d      = rr_q;
        cnt_d     = cnt_q;
        adr_d     = adr_q;
        cs_n_d    = cs_n_q;
        oe_n_d    = oe_n_q;
        rd_n_d    = rd_n_q;
        tstamp_d  = tstamp_q;
        fifo_d    = fifo_q;
        valid_d   = valid_q;
        word_done = 1'b0;
        pick      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (acq_en_i && (!ef1_s_q || !ef2_s_q)) begin
                    // Both non-empty: take the preferred FIFO. Otherwise take
                    // the non-empty one (FIFO2 exactly when FIFO1 is empty).
                    pick    = (!ef1_s_q && !ef2_s_q) ? rr_q : ef1_s_q;
                    sel_d   = pick;
                    adr_d   = pick ? ADR_FIFO2 : ADR_FIFO1;
                    cs_n_d  = 1'b0;
                    oe_n_d  = 1'b0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                rd_n_d  = 1'b0;
                cnt_d   = '0;
                state_d = S_RD;
            end
            S_RD: begin
                if (cnt_q == CNT_W'(RD_PULSE_CYCLES - 1)) begin
                    // The edge that ends the last low cycle samples the bus
                    // and releases all strobes together.
                    rd_n_d    = 1'b1;
                    cs_n_d    = 1'b1;
                    oe_n_d    = 1'b1;
                    tstamp_d  = data_i;
                    fifo_d    = sel_q;
                    valid_d   = 1'b1;
                    cnt_d     = '0;
                    word_done = 1'b1;
                    state_d   = S_OUTPUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_OUTPUT: begin
                cnt_d = cnt_sat_inc;
                if (tstamp_ready_i) begin
                    valid_d = 1'b0;
                    rr_d    = ~sel_q;
                    state_d = S_HOLDOFF;
                end
            end
            S_HOLDOFF: begin
                cnt_d = cnt_sat_inc;
                if (hold_done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= S_IDLE;
            sel_q    <= 1'b0;
            rr_q     <= 1'b0;
            cnt_q    <= '0;
            adr_q    <= 4'd0;
            cs_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            rd_n_q   <= 1'b1;
            tstamp_q <= '0;
            fifo_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            rr_q     <= rr_d;
            cnt_q    <= cnt_d;
            adr_q    <= adr_d;
            cs_n_q   <= cs_n_d;
            oe_n_q   <= oe_n_d;
            rd_n_q   <= rd_n_d;
            tstamp_q <= tstamp_d;
            fifo_q   <= fifo_d;
            valid_q  <= valid_d;
        end
    end

`ifdef ACAM_RD_STATS_EN
    logic [31:0] rd_count_q, rd_count_d;

    assign rd_count_d = word_done ? rd_count_q + 32'd1 : rd_count_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) rd_count_q <= '0;
        else          rd_count_q <= rd_count_d;
    end

    assign rd_count_o = rd_count_q;
`else
    assign rd_count_o = '0;
`endif

    assign adr_o          = adr_q;
    assign cs_n_o         = cs_n_q;
    assign oe_n_o         = oe_n_q;
    assign rd_n_o         = rd_n_q;
    assign tstamp_o       = tstamp_q;
    assign tstamp_fifo_o  = fifo_q;
    assign tstamp_valid_o = valid_q;
    // HOLDOFF is a non-IDLE state, so busy_o covers it in both builds.
    assign busy_o         = (state_q != S_IDLE);

endmodule

// File: tb/tb_acam_fifo_readout.sv
`timescale 1ns/1ps
module tb_acam_fifo_readout;

`ifdef ACAM_RD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        acq_en;
    logic        ef1, ef2;
    logic [27:0] data;
    logic [3:0]  adr_o;
    logic        cs_n_o, oe_n_o, rd_n_o;
    logic [27:0] tstamp_o;
    logic        tstamp_fifo_o, tstamp_valid_o;
    logic        ready;
    logic        busy_o;
    logic [31:0] rd_count_o;

    int total = 0;
    int bad   = 0;

    acam_fifo_readout dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .acq_en_i       (acq_en),
        .ef1_i          (ef1),
        .ef2_i          (ef2),
        .data_i         (data),
        .adr_o          (adr_o),
        .cs_n_o         (cs_n_o),
        .oe_n_o         (oe_n_o),
        .rd_n_o         (rd_n_o),
        .tstamp_o       (tstamp_o),
        .tstamp_fifo_o  (tstamp_fifo_o),
        .tstamp_valid_o (tstamp_valid_o),
        .tstamp_ready_i (ready),
        .busy_o         (busy_o),
        .rd_count_o     (rd_count_o)
    );

    always #4 clk = ~clk;

    // rd_n_o pulse monitor: start cycle and width (in clocks) of every low pulse
    int mon_cyc = 0;
    int mon_run = 0;
    int starts[$];
    int widths[$];
    always @(negedge clk) begin
        mon_cyc++;
        if (rd_n_o === 1'b0) begin
            if (mon_run == 0) starts.push_back(mon_cyc);
            mon_run++;
        end else if (mon_run != 0) begin
            widths.push_back(mon_run);
            mon_run = 0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (tstamp_valid_o !== 1'b1 && n < 40) begin tick(); n++; end
        chk(tag, {31'd0, tstamp_valid_o}, 32'd1);
    endtask

    task automatic wait_rd_low(input string tag);
        int n = 0;
        while (rd_n_o !== 1'b0 && n < 40) begin tick(); n++; end
        chk(tag, {31'd0, rd_n_o}, 32'd0);
    endtask

    task automatic wait_cs_low(input string tag);
        int n = 0;
        while (cs_n_o !== 1'b0 && n < 40) begin tick(); n++; end
        chk(tag, {31'd0, cs_n_o}, 32'd0);
    endtask

    task automatic do_reset();
        ef1    = 1'b1;
        ef2    = 1'b1;
        acq_en = 1'b0;
        ready  = 1'b0;
        rst_n  = 1'b0;
        tick(); tick();
        rst_n  = 1'b1;
        tick();
    endtask

    initial begin
        int base;
        int bw;
        bit stable;
        rst_n  = 1'b0;
        acq_en = 1'b0;
        ef1    = 1'b1;
        ef2    = 1'b1;
        data   = '0;
        ready  = 1'b0;
        tick(); tick();

        // reset state
        chk("rst rd_n",   {31'd0, rd_n_o}, 32'd1);
        chk("rst cs_n",   {31'd0, cs_n_o}, 32'd1);
        chk("rst oe_n",   {31'd0, oe_n_o}, 32'd1);
        chk("rst adr",    {28'd0, adr_o}, 32'd0);
        chk("rst tstamp", {4'd0, tstamp_o}, 32'd0);
        chk("rst fifo",   {31'd0, tstamp_fifo_o}, 32'd0);
        chk("rst valid",  {31'd0, tstamp_valid_o}, 32'd0);
        chk("rst busy",   {31'd0, busy_o}, 32'd0);
        chk("rst count",  rd_count_o, 32'd0);
        rst_n = 1'b1;
        tick();

        // T1: single word from FIFO1, cycle-accurate strobe check
        base   = starts.size();
        bw     = widths.size();
        acq_en = 1'b1;
        ready  = 1'b1;
        data   = 28'hABCDEF1;
        ef1    = 1'b0;
        wait_cs_low("T1 cs low");
        chk("T1 setup adr",  {28'd0, adr_o}, 32'd8);
        chk("T1 setup oe",   {31'd0, oe_n_o}, 32'd0);
        chk("T1 setup rd",   {31'd0, rd_n_o}, 32'd1);
        chk("T1 setup busy", {31'd0, busy_o}, 32'd1);
        tick();
        chk("T1 rd low 1",   {31'd0, rd_n_o}, 32'd0);
        tick();
        chk("T1 rd low 2",   {31'd0, rd_n_o}, 32'd0);
        tick();
        chk("T1 rd release", {31'd0, rd_n_o}, 32'd1);
        chk("T1 cs release", {31'd0, cs_n_o}, 32'd1);
        chk("T1 oe release", {31'd0, oe_n_o}, 32'd1);
        chk("T1 valid",      {31'd0, tstamp_valid_o}, 32'd1);
        chk("T1 tstamp",     {4'd0, tstamp_o}, 32'h0ABCDEF1);
        chk("T1 fifo",       {31'd0, tstamp_fifo_o}, 32'd0);
        chk("T1 count",      rd_count_o, STATS ? 32'd1 : 32'd0);
        ef1 = 1'b1;
        tick();
        chk("T1 valid 1 cycle", {31'd0, tstamp_valid_o}, 32'd0);
        repeat (20) tick();
        chk("T1 pulses", starts.size() - base, 32'd1);
        chk("T1 width",  widths[bw], 32'd2);
        chk("T1 idle",   {31'd0, busy_o}, 32'd0);

        // T2: both FIFOs non-empty, round-robin 0,1,0,1
        do_reset();
        base   = starts.size();
        bw     = widths.size();
        acq_en = 1'b1;
        ready  = 1'b1;
        ef1    = 1'b0;
        ef2    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            data = 28'h1000000 + 28'(i);
            wait_valid($sformatf("T2 valid %0d", i));
            chk($sformatf("T2 fifo %0d", i),   {31'd0, tstamp_fifo_o}, 32'(i % 2));
            chk($sformatf("T2 adr %0d", i),    {28'd0, adr_o}, 32'd8 + 32'(i % 2));
            chk($sformatf("T2 tstamp %0d", i), {4'd0, tstamp_o}, 32'h01000000 + 32'(i));
            if (i == 3) begin
                ef1 = 1'b1;
                ef2 = 1'b1;
            end
            tick();
        end
        repeat (20) tick();
        chk("T2 pulses", starts.size() - base, 32'd4);
        for (int i = 0; i < 3; i++)
            chk($sformatf("T2 period %0d", i), starts[base+i+1] - starts[base+i], 32'd8);
        for (int i = 0; i < 4; i++)
            chk($sformatf("T2 width %0d", i), widths[bw+i], 32'd2);

        // T3: back-pressure holds the word and blocks the next read
        do_reset();
        base   = starts.size();
        acq_en = 1'b1;
        ready  = 1'b0;
        data   = 28'h5555555;
        ef1    = 1'b0;
        wait_valid("T3 valid 1");
        data   = 28'h2222222;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (tstamp_valid_o !== 1'b1 || tstamp_o !== 28'h5555555 || rd_n_o !== 1'b1) stable = 1'b0;
        end
        chk("T3 stable", {31'd0, stable}, 32'd1);
        chk("T3 pulses held", starts.size() - base, 32'd1);
        ready = 1'b1;
        tick();
        chk("T3 accept drops valid", {31'd0, tstamp_valid_o}, 32'd0);
        ready = 1'b0;
        wait_valid("T3 valid 2");
        chk("T3 tstamp 2", {4'd0, tstamp_o}, 32'h02222222);
        chk("T3 pulses per accept", starts.size() - base, 32'd2);
        ef1   = 1'b1;
        ready = 1'b1;
        repeat (15) tick();

        // T4: acq_en dropped during RD; word still completes and is delivered
        do_reset();
        base   = starts.size();
        bw     = widths.size();
        acq_en = 1'b1;
        ready  = 1'b1;
        data   = 28'h1234567;
        ef1    = 1'b0;
        wait_rd_low("T4 rd low");
        acq_en = 1'b0;
        tick();
        chk("T4 rd still low", {31'd0, rd_n_o}, 32'd0);
        tick();
        chk("T4 valid",  {31'd0, tstamp_valid_o}, 32'd1);
        chk("T4 tstamp", {4'd0, tstamp_o}, 32'h01234567);
        repeat (30) tick();
        chk("T4 pulses", starts.size() - base, 32'd1);
        chk("T4 width",  widths[bw], 32'd2);
        chk("T4 idle",   {31'd0, busy_o}, 32'd0);

        // T5: async reset in the middle of the strobe
        do_reset();
        acq_en = 1'b1;
        ready  = 1'b1;
        data   = 28'h0F0F0F0;
        ef1    = 1'b0;
        wait_rd_low("T5 rd low");
        #1 rst_n = 1'b0;
        #1;
        chk("T5 rd_n async",  {31'd0, rd_n_o}, 32'd1);
        chk("T5 cs_n async",  {31'd0, cs_n_o}, 32'd1);
        chk("T5 oe_n async",  {31'd0, oe_n_o}, 32'd1);
        chk("T5 valid async", {31'd0, tstamp_valid_o}, 32'd0);
        chk("T5 busy async",  {31'd0, busy_o}, 32'd0);
        tick();
        rst_n = 1'b1;
        wait_valid("T5 restart valid");
        chk("T5 tstamp", {4'd0, tstamp_o}, 32'h00F0F0F0);
        chk("T5 fifo",   {31'd0, tstamp_fifo_o}, 32'd0);
        ef1 = 1'b1;
        tick();
        chk("T5 clean width", widths[widths.size()-1], 32'd2);
        repeat (15) tick();

        // T6: read counter and wrap
        do_reset();
        acq_en = 1'b1;
        ready  = 1'b1;
        ef1    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            data = 28'h0300000 + 28'(i);
            wait_valid($sformatf("T6 valid %0d", i));
            if (i == 2) ef1 = 1'b1;
            tick();
        end
        chk("T6 count 3", rd_count_o, STATS ? 32'd3 : 32'd0);
        repeat (15) tick();
`ifdef ACAM_RD_STATS_EN
        force dut.rd_count_q = 32'hFFFF_FFFF;
        tick();
        release dut.rd_count_q;
        tick();
        chk("T6 preload", rd_count_o, 32'hFFFF_FFFF);
`endif
        ef1 = 1'b0;
        wait_valid("T6 valid wrap");
        chk("T6 wrap", rd_count_o, 32'd0);
        ef1 = 1'b1;
        repeat (15) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
